simple_phase_ctrl: RTL and testbench
====================================

Name: simple_phase_ctrl

Overview:
- Phase sequencer and control-strobe generator for the SIMPLE 16-bit processor datapath.
- Drives the 5-phase one-hot `phase` bus: P1 fetch, P2 decode/reg-read, P3 ALU, P4 memory, P5 write-back/PC update.
- Decodes the latched instruction class and emits write enables for IR, PC, register file, flags and RAM.
- Evaluates the branch condition against `szcv` to produce `jflag`; stalls P4 on slow memory and parks on HLT.

Parameters:
- NPHASE, 5, number of phases; fixed at 5, one-hot width of `phase`.
- MEM_WAIT_MAX, 15, P4 stall cycles before `mem_timeout` pulses; width = $clog2(MEM_WAIT_MAX+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr  input  16  instruction register contents, valid from P2 onward.
- szcv  input  4  datapath flags {S,Z,C,V}, valid in P5.
- mem_ready  input  1  RAM access complete; sampled in P4.
- phase  output  5  one-hot phase; 5'b00000 when halted.
- ir_we  output  1  IR load strobe.
- pc_we  output  1  PC update strobe.
- jflag  output  1  branch taken; PC mux selects the branch target.
- rf_we  output  1  register-file write strobe.
- szcv_we  output  1  flag register write strobe.
- ram_re  output  1  RAM read strobe.
- ram_we  output  1  RAM write strobe.
- halted  output  1  processor stopped on HLT.
- mem_timeout  output  1  one-cycle pulse when the P4 stall reaches MEM_WAIT_MAX.

Behaviour:
- Reset (rst=0, async):
  - `phase` = 5'b00001; `halted` = 0; wait counter = 0.
  - All strobes = 0, including `jflag` and `mem_timeout`.
  - Reset mid-instruction aborts it; the first edge after release starts at P1.
- States: P1..P5, HALT.
  - Normal order: P1→P2→P3→P4→P5→P1, one clock each.
  - P4 holds while class ∈ {LD,ST} and mem_ready=0. Other classes leave P4 unconditionally.
- Class decode (combinational from `instr`, used P2..P5):
  - [15:14]=11: ALU, op3=[7:4]; op3=1111 is HLT.
  - 00: LD. 01: ST.
  - 10 with [13:11]=000: LI.
  - 10 with [13:11]=100: B.
  - 10 with [13:11]=111: BCC, cond=[10:8].
  - Anything else: NOP.
- HLT: in P2, next state is HALT. HALT has `phase`=0, `halted`=1, all strobes 0, and is left only by reset.
- Strobes are combinational from the state register and class, with no added latency:
  - `ir_we`=1 in P1.
  - `szcv_we`=1 in P3 for ALU except HLT.
  - `ram_re`=1 throughout P4 for LD; `ram_we`=1 throughout P4 for ST.
  - `rf_we`=1 in P5 for LD, LI, and ALU with op3 ∉ {0101 CMP, 1101 OUT, 1111 HLT}.
  - `pc_we`=1 in P5 for every class.
- Branch (`jflag`, P5 only):
  - B: 1.
  - BCC cond 000 BE: Z. 001 BLT: S^V. 010 BLE: Z|(S^V). 011 BNE: ~Z.
  - BCC cond 1xx: 0 (reserved).
  - All other classes: 0.
- Memory wait:
  - Counter increments each stalled P4 cycle and saturates at MEM_WAIT_MAX.
  - `mem_timeout` pulses on the cycle the counter reaches MEM_WAIT_MAX; the stall continues.
  - Counter clears on leaving P4.
  - mem_ready=1 in the first P4 cycle gives zero stall.

Optional Feature:
- Macro: SIMPLE_STEP_EN.
- Defined:
  - Adds input `step` (1 bit).
  - After P5, the FSM enters state WAIT (`phase`=0, strobes 0).
  - It goes to P1 on the first clock where step=1.
  - Reset enters P1 directly.
- Undefined: no `step` port and no WAIT state; P5→P1 is unconditional.

Decomposition:
- Package simple_pkg holds:
  - phase one-hot constants PH_P1..PH_P5;
  - op-class enum {CL_ALU, CL_LD, CL_ST, CL_LI, CL_B, CL_BCC, CL_NOP};
  - op3 constants OP_CMP, OP_OUT, OP_HLT;
  - branch cond codes.
- Sub-module simple_branch_eval: combinational; inputs szcv, cond, is_b, is_bcc; output taken.

Test Plan:
- Reset then release, instr=16'hC000 (ALU ADD):
  - phase cycles 00001, 00010, 00100, 01000, 10000;
  - szcv_we in P3 only; rf_we and pc_we in P5; jflag=0.
- LD (instr=16'h0000), mem_ready low for 3 P4 cycles:
  - P4 lasts 4 cycles with ram_re=1 throughout;
  - rf_we in P5; mem_timeout stays 0.
- BCC BE, instr=16'hB800, szcv=4'b0100 → jflag=1 in P5; repeat with szcv=4'b0000 → jflag=0.
- HLT, instr=16'hC0F0:
  - after P2, phase=0 and halted=1, no strobes for 20 cycles;
  - rst pulse low → phase=00001, halted=0.
- ST with mem_ready=0 for 20 cycles:
  - ram_we held for the whole stall;
  - mem_timeout pulses exactly once, after 15 stall cycles.
- rst asserted low mid-P3 (async, between edges) → phase=00001 and all strobes 0 immediately, before the next edge.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared types and encodings for the SIMPLE phase controller.
// SIMPLE_STEP_EN adds a WAIT state used for single-step operation.
package simple_pkg;

  localparam logic [4:0] PH_P1 = 5'b00001;
  localparam logic [4:0] PH_P2 = 5'b00010;
  localparam logic [4:0] PH_P3 = 5'b00100;
  localparam logic [4:0] PH_P4 = 5'b01000;
  localparam logic [4:0] PH_P5 = 5'b10000;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LD,
    CL_ST,
    CL_LI,
    CL_B,
    CL_BCC,
    CL_NOP
  } op_class_t;

  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  typedef enum logic [2:0] {
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_HALT
`ifdef SIMPLE_STEP_EN
    , ST_WAIT
`endif
  } state_t;

  // major = instr[15:14], minor = instr[13:11]
  function automatic op_class_t decode_class(input logic [1:0] major,
                                             input logic [2:0] minor);
    op_class_t cls;
    case (major)
      2'b11:   cls = CL_ALU;
      2'b00:   cls = CL_LD;
      2'b01:   cls = CL_ST;
      default: begin
        case (minor)
          3'b000:  cls = CL_LI;
          3'b100:  cls = CL_B;
          3'b111:  cls = CL_BCC;
          default: cls = CL_NOP;
        endcase
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/simple_branch_eval.sv
// Branch-taken evaluation for B and BCC against the {S,Z,C,V} flags.
module simple_branch_eval
  import simple_pkg::*;
(
  input  logic [3:0] szcv,
  input  logic [2:0] cond,
  input  logic       is_b,
  input  logic       is_bcc,
  output logic       taken
);

  logic flag_s;
  logic flag_z;
  logic flag_v;
  logic unused_carry;
  logic cond_ok;

  assign flag_s       = szcv[3];
  assign flag_z       = szcv[2];
  assign flag_v       = szcv[0];
  assign unused_carry = szcv[1];

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      CC_BE:   cond_ok = flag_z;
      CC_BLT:  cond_ok = flag_s ^ flag_v;
      CC_BLE:  cond_ok = flag_z | (flag_s ^ flag_v);
      CC_BNE:  cond_ok = ~flag_z;
      default: cond_ok = 1'b0;
    endcase
  end

  assign taken = is_b | (is_bcc & cond_ok);

endmodule

// File: rtl/simple_phase_ctrl.sv
// Five-phase sequencer and control-strobe generator for the SIMPLE datapath.
// Optional single-step mode via `define SIMPLE_STEP_EN (adds `step` input and WAIT state).
module simple_phase_ctrl
  import simple_pkg::*;
#(
  parameter int NPHASE       = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic [3:0]        szcv,
  input  logic              mem_ready,
`ifdef SIMPLE_STEP_EN
  input  logic              step,
`endif
  output logic [NPHASE-1:0] phase,
  output logic              ir_we,
  output logic              pc_we,
  output logic              jflag,
  output logic              rf_we,
  output logic              szcv_we,
  output logic              ram_re,
  output logic              ram_we,
  output logic              halted,
  output logic              mem_timeout
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT_MAX);
  localparam logic [CW-1:0] WAIT_PRE = CW'(MEM_WAIT_MAX - 1);

  state_t          state_q;
  state_t          state_d;
  op_class_t       cls;
  logic [3:0]      op3;
  logic [2:0]      cond;
  logic            is_hlt;
  logic            is_mem;
  logic            stall;
  logic            taken;
  logic [CW-1:0]   wait_cnt;
  logic            timeout_q;
  logic [4:0]      phase_vec;
  logic            unused_low;

  assign cls        = decode_class(instr[15:14], instr[13:11]);
  assign op3        = instr[7:4];
  assign cond       = instr[10:8];
  assign unused_low = ^instr[3:0];
  assign is_hlt     = (cls == CL_ALU) && (op3 == OP_HLT);
  assign is_mem     = (cls == CL_LD) || (cls == CL_ST);
  assign stall      = (state_q == ST_P4) && is_mem && !mem_ready;

  simple_branch_eval u_branch (
    .szcv   (szcv),
    .cond   (cond),
    .is_b   (cls == CL_B),
    .is_bcc (cls == CL_BCC),
    .taken  (taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_P1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_P1:   state_d = ST_P2;
      ST_P2:   state_d = is_hlt ? ST_HALT : ST_P3;
      ST_P3:   state_d = ST_P4;
      ST_P4:   state_d = stall ? ST_P4 : ST_P5;
`ifdef SIMPLE_STEP_EN
      ST_P5:   state_d = ST_WAIT;
      ST_WAIT: state_d = step ? ST_P1 : ST_WAIT;
`else
      ST_P5:   state_d = ST_P1;
`endif
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_P1;
    endcase
  end

  // Timeout flag is registered so it fires on the first cycle the saturated count is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall && (wait_cnt == WAIT_PRE);
      if (stall) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Strobes are gated by rst so an asynchronous reset silences them before the next edge.
  always_comb begin
    phase_vec = '0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    jflag     = 1'b0;
    rf_we     = 1'b0;
    szcv_we   = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_P1: begin
        phase_vec = PH_P1;
        ir_we     = rst;
      end
      ST_P2: phase_vec = PH_P2;
      ST_P3: begin
        phase_vec = PH_P3;
        szcv_we   = rst && (cls == CL_ALU) && !is_hlt;
      end
      ST_P4: begin
        phase_vec = PH_P4;
        ram_re    = rst && (cls == CL_LD);
        ram_we    = rst && (cls == CL_ST);
      end
      ST_P5: begin
        phase_vec = PH_P5;
        pc_we     = rst;
        jflag     = rst && taken;
        rf_we     = rst && ((cls == CL_LD) || (cls == CL_LI) ||
                            ((cls == CL_ALU) && (op3 != OP_CMP) &&
                             (op3 != OP_OUT) && (op3 != OP_HLT)));
      end
      ST_HALT: halted = rst;
      default: phase_vec = '0;
    endcase
  end

  assign phase       = phase_vec;
  assign mem_timeout = timeout_q;

  phase_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(phase));

endmodule

// File: tb/tb_simple_phase_ctrl.sv
// Scoreboard bench for simple_phase_ctrl: stimulus pushes hand-computed phase/strobe
// vectors, a negedge monitor pops and compares them.
module tb_simple_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic [3:0]  szcv;
  logic        mem_ready;
  logic [4:0]  phase;
  logic        ir_we, pc_we, jflag, rf_we, szcv_we, ram_re, ram_we, halted, mem_timeout;

  simple_phase_ctrl #(.NPHASE(5), .MEM_WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .szcv        (szcv),
    .mem_ready   (mem_ready),
    .phase       (phase),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .jflag       (jflag),
    .rf_we       (rf_we),
    .szcv_we     (szcv_we),
    .ram_re      (ram_re),
    .ram_we      (ram_we),
    .halted      (halted),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] PH0 = 5'b00000;
  localparam logic [4:0] PH1 = 5'b00001;
  localparam logic [4:0] PH2 = 5'b00010;
  localparam logic [4:0] PH3 = 5'b00100;
  localparam logic [4:0] PH4 = 5'b01000;
  localparam logic [4:0] PH5 = 5'b10000;

  // strobe order: {ir, pc, j, rf, szcv, re, we, halted, timeout}
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_IR   = 9'b100000000;
  localparam logic [8:0] S_PC   = 9'b010000000;
  localparam logic [8:0] S_J    = 9'b001000000;
  localparam logic [8:0] S_RF   = 9'b000100000;
  localparam logic [8:0] S_SZ   = 9'b000010000;
  localparam logic [8:0] S_RE   = 9'b000001000;
  localparam logic [8:0] S_WE   = 9'b000000100;
  localparam logic [8:0] S_H    = 9'b000000010;
  localparam logic [8:0] S_TO   = 9'b000000001;

  typedef struct {
    string      name;
    logic [13:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [13:0] act;

  assign act = {phase, ir_we, pc_we, jflag, rf_we, szcv_we, ram_re, ram_we, halted, mem_timeout};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      tests++;
      if (act !== mon_e.val) begin
        fails++;
        $display("FAIL %s: got phase=%b strobes=%b, expected phase=%b strobes=%b",
                 mon_e.name, act[13:9], act[8:0], mon_e.val[13:9], mon_e.val[8:0]);
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] ph, input logic [8:0] st);
    exp_t e;
    e.name = nm;
    e.val  = {ph, st};
    sb.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one non-memory instruction; on entry (adv=0) the DUT is already in P1.
  task automatic run_basic(input string nm, input logic [15:0] ins, input logic [3:0] f,
                           input bit sz3, input bit rf5, input bit j5, input bit adv);
    if (adv) next_cyc();
    instr = ins;
    szcv  = f;
    push({nm, "/P1"}, PH1, S_IR);
    next_cyc(); push({nm, "/P2"}, PH2, S_NONE);
    next_cyc(); push({nm, "/P3"}, PH3, sz3 ? S_SZ : S_NONE);
    next_cyc(); push({nm, "/P4"}, PH4, S_NONE);
    next_cyc(); push({nm, "/P5"}, PH5, S_PC | (rf5 ? S_RF : S_NONE) | (j5 ? S_J : S_NONE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sequence did not complete, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    instr     = 16'h0000;
    szcv      = 4'b0000;
    mem_ready = 1'b1;
    push("reset", PH1, S_NONE);
    @(negedge clk);
    next_cyc();
    rst = 1'b1;

    run_basic("ADD",     16'hC000, 4'b0000, 1, 1, 0, 0);
    run_basic("BE_z1",   16'hB800, 4'b0100, 0, 0, 1, 1);
    run_basic("BE_z0",   16'hB800, 4'b0000, 0, 0, 0, 1);
    run_basic("B",       16'hA000, 4'b0000, 0, 0, 1, 1);
    run_basic("LI",      16'h8000, 4'b0000, 0, 1, 0, 1);
    run_basic("BNE_z0",  16'hBB00, 4'b0000, 0, 0, 1, 1);
    run_basic("BNE_z1",  16'hBB00, 4'b0100, 0, 0, 0, 1);
    run_basic("BLT_s",   16'hB900, 4'b1000, 0, 0, 1, 1);
    run_basic("BLT_sv",  16'hB900, 4'b1001, 0, 0, 0, 1);
    run_basic("BLE_z",   16'hBA00, 4'b0100, 0, 0, 1, 1);
    run_basic("BCC_rsv", 16'hBC00, 4'b0100, 0, 0, 0, 1);
    run_basic("CMP",     16'hC050, 4'b0000, 1, 0, 0, 1);
    run_basic("OUT",     16'hC0D0, 4'b0000, 1, 0, 0, 1);
    run_basic("NOP",     16'h8800, 4'b0000, 0, 0, 0, 1);

    // LD with three stalled P4 cycles
    next_cyc(); instr = 16'h0000; push("LD/P1", PH1, S_IR);
    next_cyc(); push("LD/P2", PH2, S_NONE);
    next_cyc(); push("LD/P3", PH3, S_NONE);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      mem_ready = (k == 4);
      push($sformatf("LD/P4_%0d", k), PH4, S_RE);
    end
    next_cyc(); push("LD/P5", PH5, S_PC | S_RF);

    // ST stalled 20 cycles: timeout visible on the 16th P4 cycle only
    next_cyc(); instr = 16'h4000; push("ST/P1", PH1, S_IR);
    next_cyc(); push("ST/P2", PH2, S_NONE);
    next_cyc(); push("ST/P3", PH3, S_NONE);
    for (int k = 1; k <= 21; k++) begin
      next_cyc();
      mem_ready = (k == 21);
      push($sformatf("ST/P4_%0d", k), PH4, S_WE | ((k == 16) ? S_TO : S_NONE));
    end
    next_cyc(); push("ST/P5", PH5, S_PC);

    // HLT parks until reset
    next_cyc(); instr = 16'hC0F0; push("HLT/P1", PH1, S_IR);
    next_cyc(); push("HLT/P2", PH2, S_NONE);
    for (int k = 1; k <= 20; k++) begin
      next_cyc();
      push($sformatf("HLT/park_%0d", k), PH0, S_H);
    end
    next_cyc(); rst = 1'b0; push("HLT/rst", PH1, S_NONE);
    next_cyc(); rst = 1'b1;
    run_basic("ADD_post_hlt", 16'hC000, 4'b0000, 1, 1, 0, 0);

    // Asynchronous reset in the middle of P3
    next_cyc(); instr = 16'hC000; push("ARST/P1", PH1, S_IR);
    next_cyc(); push("ARST/P2", PH2, S_NONE);
    next_cyc(); #1; rst = 1'b0; push("ARST/mid_p3", PH1, S_NONE);
    next_cyc(); rst = 1'b1;
    run_basic("ADD_post_arst", 16'hC000, 4'b0000, 1, 1, 0, 0);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
